// File: rtl/bft_leaf_interface.sv
`default_nettype none
// ============================================================================
// Module   : bft_leaf_interface
// Purpose  : Leaf endpoint for the butterfly-fat-tree network. It packs and
//            paces TX words onto the bus and filters and buffers RX packets.
// Revision : 1.0
// ============================================================================
module bft_leaf_interface #(
    parameter int num_leaves  = 2,
    parameter int payload_sz  = 1,
    parameter int addr        = 0,
    parameter int tx_depth    = 16,
    parameter int rx_depth    = 16,
    parameter int inj_gap     = 0,
    localparam int aw         = $clog2(num_leaves),
    localparam int p_sz       = 1 + aw + payload_sz
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic [aw-1:0]               tx_dest_i,
    input  logic [payload_sz-1:0]       tx_data_i,
    output logic [p_sz-1:0]             bus_o,
    input  logic [p_sz-1:0]             bus_i,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [payload_sz-1:0]       rx_data_o,
    output logic [$clog2(tx_depth):0]   tx_level_o,
    output logic [$clog2(rx_depth):0]   rx_level_o,
    output logic [15:0]                 drop_cnt_o,
    output logic [15:0]                 misroute_cnt_o
);

    localparam int            c_tw   = $clog2(tx_depth);
    localparam int            c_rw   = $clog2(rx_depth);
    localparam int            c_gw   = (inj_gap > 0) ? $clog2(inj_gap + 1) : 1;
    localparam logic [aw-1:0] c_addr = aw'(addr);

    // ---------------- TX path ----------------
    logic [aw+payload_sz-1:0] r_tx_mem [tx_depth];
    logic [c_tw:0]            r_tx_wr, r_tx_rd;
    logic [c_gw-1:0]          r_gap;
    logic [p_sz-1:0]          r_bus;
    logic [c_tw:0]            w_tx_level;
    logic                     w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

    assign w_tx_level = r_tx_wr - r_tx_rd;
    assign w_tx_full  = (w_tx_level == (c_tw+1)'(tx_depth));
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    // Ready depends only on stored pointers, so a same-cycle pop never frees a slot.
    assign w_tx_push  = tx_valid_i && !w_tx_full;
    assign w_tx_pop   = !w_tx_empty && (r_gap == '0);

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[c_tw-1:0]] <= {tx_dest_i, tx_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
            r_gap   <= '0;
            r_bus   <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) begin
                r_bus   <= {1'b1, r_tx_mem[r_tx_rd[c_tw-1:0]]};
                r_tx_rd <= r_tx_rd + 1'b1;
                r_gap   <= c_gw'(inj_gap);
            end else begin
                r_bus <= '0;
                if (r_gap != '0) begin
                    r_gap <= r_gap - 1'b1;
                end
            end
        end
    end

    assign bus_o      = r_bus;
    assign tx_ready_o = !w_tx_full;
    assign tx_level_o = w_tx_level;

    // ---------------- RX path ----------------
    logic [p_sz-1:0]       r_cap;
    logic [payload_sz-1:0] r_rx_mem [rx_depth];
    logic [c_rw:0]         r_rx_wr, r_rx_rd;
    logic [15:0]           r_drop, r_misroute;
    logic [c_rw:0]         w_rx_level;
    logic                  w_rx_full, w_rx_empty, w_rx_pop, w_rx_push;
    logic                  w_cap_valid, w_cap_mine, w_drop, w_misroute;

    assign w_rx_level  = r_rx_wr - r_rx_rd;
    assign w_rx_full   = (w_rx_level == (c_rw+1)'(rx_depth));
    assign w_rx_empty  = (r_rx_wr == r_rx_rd);
    assign w_rx_pop    = !w_rx_empty && rx_ready_i;
    assign w_cap_valid = r_cap[p_sz-1];
    assign w_cap_mine  = (r_cap[p_sz-2:payload_sz] == c_addr);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_rx_push   = w_cap_valid && w_cap_mine && (!w_rx_full || w_rx_pop);
    assign w_drop      = w_cap_valid && w_cap_mine && w_rx_full && !w_rx_pop;
    assign w_misroute  = w_cap_valid && !w_cap_mine;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[c_rw-1:0]] <= r_cap[payload_sz-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap      <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_drop     <= '0;
            r_misroute <= '0;
        end else begin
            r_cap <= bus_i;
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + 1'b1;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
            if (w_misroute && (r_misroute != 16'hFFFF)) begin
                r_misroute <= r_misroute + 16'd1;
            end
        end
    end

    assign rx_valid_o     = !w_rx_empty;
    assign rx_data_o      = r_rx_mem[r_rx_rd[c_rw-1:0]];
    assign rx_level_o     = w_rx_level;
    assign drop_cnt_o     = r_drop;
    assign misroute_cnt_o = r_misroute;

endmodule
`default_nettype wire

// File: tb/tb_bft_leaf_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_bft_leaf_interface
// Purpose  : Directed self-checking bench for bft_leaf_interface (two configs).
// Revision : 1.0
// ============================================================================
module tb_bft_leaf_interface;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    // Instance A: inj_gap=0, tx_depth=4, rx_depth=16
    logic        a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
    logic [1:0]  a_tx_dest;
    logic [7:0]  a_tx_data, a_rx_data;
    logic [10:0] a_bus_o, a_bus_i;
    logic [2:0]  a_tx_level;
    logic [4:0]  a_rx_level;
    logic [15:0] a_drop, a_mis;

    // Instance B: inj_gap=2, tx_depth=4, rx_depth=16
    logic        b_tx_valid, b_tx_ready, b_rx_valid;
    logic [1:0]  b_tx_dest;
    logic [7:0]  b_tx_data, b_rx_data;
    logic [10:0] b_bus_o, b_bus_i;
    logic [2:0]  b_tx_level;
    logic [4:0]  b_rx_level;
    logic [15:0] b_drop, b_mis;

    always #5 clk = ~clk;

    bft_leaf_interface #(
        .num_leaves(4), .payload_sz(8), .addr(1),
        .tx_depth(4), .rx_depth(16), .inj_gap(0)
    ) u_a (
        .clk(clk), .reset(reset),
        .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready),
        .tx_dest_i(a_tx_dest), .tx_data_i(a_tx_data),
        .bus_o(a_bus_o), .bus_i(a_bus_i),
        .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready), .rx_data_o(a_rx_data),
        .tx_level_o(a_tx_level), .rx_level_o(a_rx_level),
        .drop_cnt_o(a_drop), .misroute_cnt_o(a_mis)
    );

    bft_leaf_interface #(
        .num_leaves(4), .payload_sz(8), .addr(1),
        .tx_depth(4), .rx_depth(16), .inj_gap(2)
    ) u_b (
        .clk(clk), .reset(reset),
        .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
        .tx_dest_i(b_tx_dest), .tx_data_i(b_tx_data),
        .bus_o(b_bus_o), .bus_i(b_bus_i),
        .rx_valid_o(b_rx_valid), .rx_ready_i(1'b0), .rx_data_o(b_rx_data),
        .tx_level_o(b_tx_level), .rx_level_o(b_rx_level),
        .drop_cnt_o(b_drop), .misroute_cnt_o(b_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (a_bus_o !== 11'h0) begin errors++; $display("FAIL reset_bus_o got %h exp %h", a_bus_o, 11'h0); end
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", a_tx_ready); end
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", a_rx_valid); end
        checks++; if ({a_tx_level, a_rx_level} !== 8'h0) begin errors++; $display("FAIL reset_levels got %h exp 0", {a_tx_level, a_rx_level}); end
        checks++; if ({a_drop, a_mis} !== 32'h0) begin errors++; $display("FAIL reset_counters got %h exp 0", {a_drop, a_mis}); end
        checks++; if ({b_bus_o, b_tx_ready} !== 12'h001) begin errors++; $display("FAIL reset_b_bus_ready got %h exp 001", {b_bus_o, b_tx_ready}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_inject();
        a_tx_valid = 1'b1; a_tx_dest = 2'd2; a_tx_data = 8'hA5;
        tick();
        checks++; if (a_bus_o !== 11'h0) begin errors++; $display("FAIL inj_latency got %h exp %h", a_bus_o, 11'h0); end
        checks++; if (a_tx_level !== 3'd1) begin errors++; $display("FAIL inj_level1 got %0d exp 1", a_tx_level); end
        a_tx_dest = 2'd3; a_tx_data = 8'h5A;
        tick();
        checks++; if (a_bus_o !== 11'h6A5) begin errors++; $display("FAIL inj_first got %h exp %h", a_bus_o, 11'h6A5); end
        a_tx_valid = 1'b0;
        tick();
        checks++; if (a_bus_o !== 11'h75A) begin errors++; $display("FAIL inj_second got %h exp %h", a_bus_o, 11'h75A); end
        tick();
        checks++; if (a_bus_o !== 11'h0) begin errors++; $display("FAIL inj_idle got %h exp %h", a_bus_o, 11'h0); end
        checks++; if (a_tx_level !== 3'd0) begin errors++; $display("FAIL inj_level0 got %0d exp 0", a_tx_level); end
    endtask

    task automatic test_gap();
        logic [10:0] words   [3];
        logic [10:0] exp_bus [9];
        logic [2:0]  exp_lvl [9];
        words   = '{{1'b1, 2'd0, 8'h11}, {1'b1, 2'd2, 8'h22}, {1'b1, 2'd3, 8'h33}};
        exp_bus = '{11'h0, words[0], 11'h0, 11'h0, words[1], 11'h0, 11'h0, words[2], 11'h0};
        exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 9; i++) begin
            b_tx_valid = (i < 3);
            if (i < 3) begin
                b_tx_dest = words[i][9:8];
                b_tx_data = words[i][7:0];
            end
            tick();
            checks++; if (b_bus_o !== exp_bus[i]) begin errors++; $display("FAIL gap_bus[%0d] got %h exp %h", i, b_bus_o, exp_bus[i]); end
            checks++; if (b_tx_level !== exp_lvl[i]) begin errors++; $display("FAIL gap_level[%0d] got %0d exp %0d", i, b_tx_level, exp_lvl[i]); end
        end
        b_tx_valid = 1'b0;
    endtask

    task automatic test_tx_full();
        logic [10:0] sb  [$];
        logic [10:0] got [$];
        int          acc = 0;
        int          n;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 12; i++) begin
            if (!b_tx_ready) break;
            b_tx_valid = 1'b1;
            b_tx_dest  = i[1:0];
            b_tx_data  = 8'(i * 7 + 1);
            sb.push_back({1'b1, b_tx_dest, b_tx_data});
            tick();
            acc++;
            if (b_bus_o[10]) got.push_back(b_bus_o);
        end
        b_tx_valid = 1'b0;
        checks++; if (acc != 6) begin errors++; $display("FAIL full_accepted got %0d exp 6", acc); end
        checks++; if (b_tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", b_tx_ready); end
        checks++; if (b_tx_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", b_tx_level); end
        for (int j = 0; j < 30; j++) begin
            tick();
            if (b_bus_o[10]) got.push_back(b_bus_o);
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL full_pkt_count got %0d exp 6", got.size()); end
        n = (got.size() < sb.size()) ? got.size() : sb.size();
        for (int k = 0; k < n; k++) begin
            checks++; if (got[k] !== sb[k]) begin errors++; $display("FAIL full_order[%0d] got %h exp %h", k, got[k], sb[k]); end
        end
        checks++; if ({b_tx_ready, b_tx_level} !== 4'b1000) begin errors++; $display("FAIL full_drained got %b exp 1000", {b_tx_ready, b_tx_level}); end
    endtask

    task automatic test_rx_overflow();
        a_rx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            a_bus_i = {1'b1, 2'd1, 8'(i)};
            tick();
        end
        a_bus_i = '0;
        tick();
        tick();
        checks++; if (a_rx_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", a_rx_level); end
        checks++; if (a_drop !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", a_drop); end
        checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", a_rx_valid); end
        a_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (a_rx_valid !== 1'b1 || a_rx_data !== 8'(i)) begin
                errors++; $display("FAIL ovf_data[%0d] got v=%b d=%h exp v=1 d=%h", i, a_rx_valid, a_rx_data, 8'(i));
            end
            tick();
        end
        a_rx_ready = 1'b0;
        checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_valid got %b exp 0", a_rx_valid); end
        checks++; if (a_rx_level !== 5'd0) begin errors++; $display("FAIL ovf_empty_level got %0d exp 0", a_rx_level); end
    endtask

    task automatic test_misroute();
        a_bus_i = {1'b1, 2'd0, 8'hAA}; tick();
        a_bus_i = {1'b1, 2'd3, 8'hBB}; tick();
        a_bus_i = {1'b0, 2'd1, 8'hCC}; tick();
        a_bus_i = '0;
        tick();
        tick();
        checks++; if (a_mis !== 16'd2) begin errors++; $display("FAIL mis_count got %0d exp 2", a_mis); end
        checks++; if (a_rx_level !== 5'd0 || a_rx_valid !== 1'b0) begin errors++; $display("FAIL mis_fifo got lvl=%0d v=%b exp 0 0", a_rx_level, a_rx_valid); end
        checks++; if (a_drop !== 16'd2) begin errors++; $display("FAIL mis_drop got %0d exp 2", a_drop); end
    endtask

    task automatic test_reset_mid();
        a_rx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a_bus_i    = (i < 8) ? {1'b1, 2'd1, 8'(64 + i)} : {1'b1, 2'd1, 8'hEE};
            b_tx_valid = (i >= 6);
            b_tx_dest  = 2'd2;
            b_tx_data  = 8'(i);
            tick();
        end
        b_tx_valid = 1'b0;
        checks++; if (a_rx_level !== 5'd8) begin errors++; $display("FAIL mid_pre_rx_level got %0d exp 8", a_rx_level); end
        checks++; if (b_tx_level !== 3'd2) begin errors++; $display("FAIL mid_pre_tx_level got %0d exp 2", b_tx_level); end
        reset   = 1'b1;
        a_bus_i = '0;
        tick();
        checks++; if ({a_bus_o, b_bus_o} !== 22'h0) begin errors++; $display("FAIL mid_bus got %h exp 0", {a_bus_o, b_bus_o}); end
        checks++; if ({a_rx_valid, a_rx_level} !== 6'h0) begin errors++; $display("FAIL mid_rx got %h exp 0", {a_rx_valid, a_rx_level}); end
        checks++; if ({a_tx_ready, b_tx_ready, b_tx_level} !== 5'b11000) begin errors++; $display("FAIL mid_tx got %b exp 11000", {a_tx_ready, b_tx_ready, b_tx_level}); end
        checks++; if ({a_drop, a_mis} !== 32'h0) begin errors++; $display("FAIL mid_counters got %h exp 0", {a_drop, a_mis}); end
        reset = 1'b0;
        tick();
        tick();
        tick();
        checks++; if ({a_rx_valid, a_rx_level} !== 6'h0) begin errors++; $display("FAIL mid_capture_delivered got %h exp 0", {a_rx_valid, a_rx_level}); end
        checks++; if ({a_drop, a_mis} !== 32'h0) begin errors++; $display("FAIL mid_capture_counted got %h exp 0", {a_drop, a_mis}); end
        checks++; if ({a_bus_o, b_bus_o} !== 22'h0) begin errors++; $display("FAIL mid_post_bus got %h exp 0", {a_bus_o, b_bus_o}); end
    endtask

    initial begin
        reset      = 1'b1;
        a_tx_valid = 1'b0; a_tx_dest = '0; a_tx_data = '0; a_bus_i = '0; a_rx_ready = 1'b0;
        b_tx_valid = 1'b0; b_tx_dest = '0; b_tx_data = '0; b_bus_i = '0;
        test_reset();
        test_inject();
        test_gap();
        test_tx_full();
        test_rx_overflow();
        test_misroute();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
